// File: rtl/unpacked_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unpacked_serializer_pkg
// Description : Shared types and helpers for the unpacked_serializer block:
//               FSM state enum, default frame geometry, and an XOR reduction
//               over an unpacked element array (used for the optional parity
//               beat and by verification models).
// Revision    : 1.0 - initial release
// ============================================================================
package unpacked_serializer_pkg;

  localparam int DEF_N_ELEM = 8;
  localparam int DEF_W      = 1;

  // Upper bounds for the generic reduction helper. Callers zero-pad their
  // frame into elem_arr_t; zero elements do not disturb an XOR.
  localparam int MAX_N_ELEM = 64;
  localparam int MAX_W      = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef logic [MAX_W-1:0] elem_t;
  typedef elem_t elem_arr_t [MAX_N_ELEM];

  function automatic elem_t xor_reduce(input elem_arr_t a);
    elem_t acc;
    acc = '0;
    for (int i = 0; i < MAX_N_ELEM; i++) begin
      acc = acc ^ a[i];
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/unpacked_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_if
// Description : Parallel frame interface: an unpacked array of N_ELEM
//               elements of W bits plus a valid/ready load handshake.
//               master drives load_valid/data, slave drives load_ready.
// Signals     : load_valid - frame offered (master -> slave)
//               load_ready - slave can accept a frame (slave -> master)
//               data       - unpacked frame elements (master -> slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_if #(
  parameter int N_ELEM = unpacked_serializer_pkg::DEF_N_ELEM,
  parameter int W      = unpacked_serializer_pkg::DEF_W
);
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] data [N_ELEM];

  modport master (output load_valid, output data, input load_ready);
  modport slave  (input load_valid, input data, output load_ready);
endinterface
`default_nettype wire

// File: rtl/unpacked_serializer.sv
`default_nettype none
// ============================================================================
// Module      : unpacked_serializer
// Description : Samples a parallel unpacked-array frame in one load handshake
//               and emits it as a serial stream, element 0 first, one element
//               per accepted beat, with a last-beat marker.
// Parameters  : N_ELEM - elements per frame (>= 2)
//               W      - bits per element
// Ports       : i_clk        - clock, rising edge
//               i_rst_n      - asynchronous active-low reset
//               load         - frame_if.slave (load_valid, load_ready, data)
//               o_ser_valid  - serial beat valid
//               i_ser_ready  - downstream accepts beat
//               o_ser_data   - current element
//               o_ser_last   - final beat of frame
// Options     : UNPACKED_SERIALIZER_PARITY_EN - append one beat carrying the
//               XOR of all elements; o_ser_last then marks that beat only.
// Revision    : 1.0 - initial release
// ============================================================================
module unpacked_serializer
  import unpacked_serializer_pkg::*;
#(
  parameter int N_ELEM = DEF_N_ELEM,
  parameter int W      = DEF_W
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst_n,
  frame_if.slave            load,
  output logic              o_ser_valid,
  input  wire logic         i_ser_ready,
  output logic [W-1:0]      o_ser_data,
  output logic              o_ser_last
);

  localparam int IW = $clog2(N_ELEM + 1);

`ifdef UNPACKED_SERIALIZER_PARITY_EN
  localparam int N_BEATS = N_ELEM + 1;
`else
  localparam int N_BEATS = N_ELEM;
`endif

  localparam logic [IW-1:0] LAST_IDX = IW'(N_BEATS - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic [W-1:0]  frame_q [N_ELEM];
  logic [W-1:0]  frame_d [N_ELEM];

  logic w_load_hs;
  logic w_beat_hs;
  logic w_is_last;

  assign w_load_hs = (state_q == IDLE) && load.load_valid;
  assign w_beat_hs = (state_q == SHIFT) && i_ser_ready;
  assign w_is_last = (idx_q == LAST_IDX);

  // --------------------------------------------------------------------------
  // State, counter and frame buffer registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;

    case (state_q)
      IDLE: begin
        if (w_load_hs) begin
          // The whole frame is captured here; later changes on data are
          // invisible until the next load handshake.
          for (int i = 0; i < N_ELEM; i++) begin
            frame_d[i] = load.data[i];
          end
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (w_beat_hs) begin
          idx_d = idx_q + IW'(1);
          if (w_is_last) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef UNPACKED_SERIALIZER_PARITY_EN
  // Parity of the captured frame, computed from the buffer so the parity
  // beat stays a function of registered state only.
  elem_arr_t    w_pad;
  logic [W-1:0] w_parity;

  always_comb begin
    w_pad = '{default: '0};
    for (int i = 0; i < N_ELEM; i++) begin
      w_pad[i] = elem_t'(frame_q[i]);
    end
  end

  assign w_parity = W'(xor_reduce(w_pad));
`endif

  // --------------------------------------------------------------------------
  // Outputs: decoded from state/idx/buffer only
  // --------------------------------------------------------------------------
  assign load.load_ready = (state_q == IDLE);
  assign o_ser_valid     = (state_q == SHIFT);
  assign o_ser_last      = (state_q == SHIFT) && w_is_last;

  always_comb begin
    o_ser_data = '0;
    if (state_q == SHIFT) begin
      for (int i = 0; i < N_ELEM; i++) begin
        if (idx_q == IW'(i)) begin
          o_ser_data = frame_q[i];
        end
      end
`ifdef UNPACKED_SERIALIZER_PARITY_EN
      if (idx_q == IW'(N_ELEM)) begin
        o_ser_data = w_parity;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_unpacked_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_unpacked_serializer
// Description : Self-checking bench for unpacked_serializer. Two instances:
//               A (N_ELEM=8, W=1) and B (N_ELEM=4, W=4). Stimulus pushes
//               expected beats into per-instance queues; monitors pop and
//               compare on every accepted beat.
// Options     : UNPACKED_SERIALIZER_PARITY_EN - expectations include the
//               trailing parity beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unpacked_serializer;
  import unpacked_serializer_pkg::*;

`ifdef UNPACKED_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB_A = 8 + PAR;

  typedef struct {
    logic [3:0] d;
    logic       l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ready_a, ready_b;
  logic valid_a, valid_b;
  logic last_a,  last_b;
  logic [0:0] data_a;
  logic [3:0] data_b;

  int total = 0;
  int bad   = 0;

  beat_t exp_a[$];
  beat_t exp_b[$];

  always #5 clk = ~clk;

  frame_if #(.N_ELEM(8), .W(1)) fa ();
  frame_if #(.N_ELEM(4), .W(4)) fb ();

  unpacked_serializer #(.N_ELEM(8), .W(1)) u_a (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .load        (fa.slave),
    .o_ser_valid (valid_a),
    .i_ser_ready (ready_a),
    .o_ser_data  (data_a),
    .o_ser_last  (last_a)
  );

  unpacked_serializer #(.N_ELEM(4), .W(4)) u_b (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .load        (fb.slave),
    .o_ser_valid (valid_b),
    .i_ser_ready (ready_b),
    .o_ser_data  (data_b),
    .o_ser_last  (last_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n && valid_a && ready_a) begin
      if (exp_a.size() == 0) begin
        chk("a_unexpected_beat", 32'd1, 32'd0);
      end else begin
        beat_t e;
        e = exp_a.pop_front();
        chk("a_data", {31'd0, data_a}, {28'd0, e.d});
        chk("a_last", {31'd0, last_a}, {31'd0, e.l});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid_b && ready_b) begin
      if (exp_b.size() == 0) begin
        chk("b_unexpected_beat", 32'd1, 32'd0);
      end else begin
        beat_t e;
        e = exp_b.pop_front();
        chk("b_data", {28'd0, data_b}, {28'd0, e.d});
        chk("b_last", {31'd0, last_b}, {31'd0, e.l});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Offers a frame on A (bit i = element i) and returns once the handshake
  // edge has passed; n_wait counts negedges spent waiting for load_ready.
  task automatic load_a(input logic [7:0] bits, output int n_wait);
    elem_arr_t pad;
    elem_t     par;
    beat_t     b;
    n_wait = 0;
    fa.load_valid = 1'b1;
    for (int i = 0; i < 8; i++) fa.data[i] = bits[i];
    @(negedge clk);
    while (!fa.load_ready && n_wait < 40) begin
      @(negedge clk);
      n_wait++;
    end
    if (n_wait >= 40) chk("a_load_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    fa.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) fa.data[i] = ~bits[i];
    pad = '{default: '0};
    for (int i = 0; i < 8; i++) begin
      pad[i] = {31'd0, bits[i]};
      b.d = {3'd0, bits[i]};
      b.l = (i == 7) && (PAR == 0);
      exp_a.push_back(b);
    end
`ifdef UNPACKED_SERIALIZER_PARITY_EN
    par = xor_reduce(pad);
    b.d = {3'd0, par[0]};
    b.l = 1'b1;
    exp_a.push_back(b);
`else
    par = '0;
    if (par != '0) $display("unreachable");
`endif
  endtask

  task automatic load_b(input logic [15:0] v);
    int    n;
    beat_t b;
    n = 0;
    fb.load_valid = 1'b1;
    for (int i = 0; i < 4; i++) fb.data[i] = v[4*i +: 4];
    @(negedge clk);
    while (!fb.load_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("b_load_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    fb.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) fb.data[i] = 4'h5;
    for (int i = 0; i < 4; i++) begin
      b.d = v[4*i +: 4];
      b.l = (i == 3) && (PAR == 0);
      exp_b.push_back(b);
    end
`ifdef UNPACKED_SERIALIZER_PARITY_EN
    b.d = 4'h6;  // A ^ 3 ^ F ^ 0
    b.l = 1'b1;
    exp_b.push_back(b);
`endif
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while ((exp_a.size() != 0 || !fa.load_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("a_drain", {31'd0, n < 60}, 32'd1);
    chk("a_queue_empty", exp_a.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain_b();
    int n;
    n = 0;
    while ((exp_b.size() != 0 || !fb.load_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("b_drain", {31'd0, n < 60}, 32'd1);
    chk("b_queue_empty", exp_b.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int nw;
    int c;
    int viol;

    rst_n         = 1'b0;
    ready_a       = 1'b1;
    ready_b       = 1'b1;
    fa.load_valid = 1'b0;
    fb.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) fa.data[i] = 1'b1;
    for (int i = 0; i < 4; i++) fb.data[i] = 4'hF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_load_ready", {31'd0, fa.load_ready}, 32'd1);
    chk("rst_a_valid",      {31'd0, valid_a},       32'd0);
    chk("rst_a_data",       {31'd0, data_a},        32'd0);
    chk("rst_a_last",       {31'd0, last_a},        32'd0);
    chk("rst_b_load_ready", {31'd0, fb.load_ready}, 32'd1);
    chk("rst_b_valid",      {31'd0, valid_b},       32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame 1,0,1,1,0,0,1,0 and load_ready return timing
    load_a(8'h4D, nw);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!fa.load_ready && c < 40);
    chk("a_ready_return_cycle", c, NB_A + 1);
    drain_a();

    // Backpressure at element index 4 (value 0) for 3 cycles
    load_a(8'h4D, nw);
    repeat (4) @(posedge clk);
    #1;
    ready_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, valid_a}, 32'd1);
      chk("bp_data",  {31'd0, data_a},  32'd0);
      chk("bp_last",  {31'd0, last_a},  32'd0);
      @(posedge clk);
    end
    #1;
    ready_a = 1'b1;
    drain_a();

    // Reset mid-frame at beat 3
    load_a(8'h4D, nw);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid",      {31'd0, valid_a},       32'd0);
    chk("midrst_load_ready", {31'd0, fa.load_ready}, 32'd1);
    chk("midrst_last",       {31'd0, last_a},        32'd0);
    exp_a.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    viol = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid_a) viol++;
    end
    chk("midrst_residual_beats", viol, 32'd0);
    @(posedge clk);
    #1;

    // Load ignored during SHIFT: all-ones frame waits for IDLE
    load_a(8'h4D, nw);
    load_a(8'hFF, nw);
    chk("ignore_wait_cycles", nw, NB_A);
    drain_a();

    // Instance B: W=4, N_ELEM=4 frame A,3,F,0
    load_b(16'h0F3A);
    drain_b();

    // Instance B with a stall on the first beat
    ready_b = 1'b0;
    load_b(16'h0F3A);
    repeat (2) @(posedge clk);
    #1;
    ready_b = 1'b1;
    drain_b();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
